// File: rtl/mips_mc_pkg.sv
// Shared types for the multicycle MIPS sequencer: states, opcodes, encodings.
// Optional illegal-opcode trapping is enabled with MIPS_MC_TRAP_EN.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC     = 4'd7,
    S_R_WB     = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_ADDI_EX  = 4'd11,
    S_ADDI_WB  = 4'd12,
    S_TRAP     = 4'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_4      = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/mips_mc_outdec.sv
// Combinational state-to-control decode for the multicycle sequencer.
// Only FETCH looks at mem_ready, to gate the IR and PC loads.
module mips_mc_outdec
  import mips_mc_pkg::*;
(
  input  state_e     state_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    unique case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_4;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.pc_source = PCS_ALU;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b = SRCB_IMM_SH;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_MEM_ADDR, S_ADDI_EX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.i_or_d    = 1'b1;
      end
      S_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_B;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SRCB_B;
        ctrl_o.alu_op        = ALU_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCS_ALUOUT;
      end
      S_JUMP: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCS_JUMP;
      end
      S_ADDI_WB: begin
        ctrl_o.reg_write = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM: state register, dispatch and retire counter.
// Define MIPS_MC_TRAP_EN to trap on illegal opcodes instead of treating them as NOPs.
module mips_mc_control
  import mips_mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             busy,
  output logic             trap,
  output logic [CNT_W-1:0] instr_count,
  output logic [3:0]       state_o
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              done;
  ctrl_t             ctrl;
  state_e            next_boundary;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign next_boundary = run ? S_FETCH : S_IDLE;

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    unique case (state_q)
      S_IDLE: if (run) state_d = S_FETCH;
      S_FETCH: if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          (opcode == OP_LW) || (opcode == OP_SW):
            state_d = S_MEM_ADDR;
          (opcode == OP_RTYPE): state_d = S_EXEC;
          (opcode == OP_BEQ):   state_d = S_BRANCH;
          (opcode == OP_J):     state_d = S_JUMP;
          (opcode == OP_ADDI):  state_d = S_ADDI_EX;
          default: begin
`ifdef MIPS_MC_TRAP_EN
            state_d = S_TRAP;
`else
            state_d = next_boundary;
            done    = 1'b1;
`endif
          end
        endcase
      end
      S_MEM_ADDR:
        state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WR: begin
        if (mem_ready) begin
          state_d = next_boundary;
          done    = 1'b1;
        end
      end
      S_EXEC:    state_d = S_R_WB;
      S_ADDI_EX: state_d = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: begin
        state_d = next_boundary;
        done    = 1'b1;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (done) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  mips_mc_outdec u_outdec (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl)
  );

  always_comb begin
    pc_en      = ctrl.pc_write | (ctrl.pc_write_cond & alu_zero);
    i_or_d     = ctrl.i_or_d;
    mem_read   = ctrl.mem_read;
    mem_write  = ctrl.mem_write;
    ir_write   = ctrl.ir_write;
    reg_dst    = ctrl.reg_dst;
    mem_to_reg = ctrl.mem_to_reg;
    reg_write  = ctrl.reg_write;
    alu_src_a  = ctrl.alu_src_a;
    alu_src_b  = ctrl.alu_src_b;
    alu_op     = ctrl.alu_op;
    pc_source  = ctrl.pc_source;
    busy       = (state_q != S_IDLE) && (state_q != S_TRAP);
`ifdef MIPS_MC_TRAP_EN
    trap       = (state_q == S_TRAP);
`else
    trap       = 1'b0;
`endif
  end

  assign instr_count = cnt_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed scoreboard bench for mips_mc_control, checked cycle by cycle.
// Covers both MIPS_MC_TRAP_EN builds.
module tb_mips_mc_control;
  import mips_mc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic [5:0]  opcode = 6'h00;
  logic        alu_zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        pc_en, i_or_d, mem_read, mem_write, ir_write;
  logic        reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic        busy, trap;
  logic [31:0] instr_count;
  logic [3:0]  state_o;

  typedef struct {
    logic [3:0]  st;
    logic [16:0] ctl;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          n_assert = 0;
  int          n_fail = 0;
  logic [31:0] exp_cnt = 0;

  mips_mc_control #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode),
    .alu_zero(alu_zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .busy(busy), .trap(trap),
    .instr_count(instr_count), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // {pc_en,i_or_d,rd,wr,ir,dst,m2r,rw,srca,srcb,aluop,pcs,busy,trap}
  function automatic logic [16:0] exp_ctl(input logic [3:0] s,
                                          input logic mr,
                                          input logic z);
    logic pe, iod, rd, wr, ir, dst, m2r, rw, sa, bz, tp;
    logic [1:0] sb_, op, ps;
    {pe, iod, rd, wr, ir, dst, m2r, rw, sa} = '0;
    sb_ = 2'b00; op = 2'b00; ps = 2'b00; bz = 1'b1; tp = 1'b0;
    case (s)
      4'd0:  bz = 1'b0;
      4'd1:  begin rd = 1; sb_ = 2'b01; ir = mr; pe = mr; end
      4'd2:  sb_ = 2'b11;
      4'd3:  begin sa = 1; sb_ = 2'b10; end
      4'd4:  begin rd = 1; iod = 1; end
      4'd5:  begin rw = 1; m2r = 1; end
      4'd6:  begin wr = 1; iod = 1; end
      4'd7:  begin sa = 1; op = 2'b10; end
      4'd8:  begin rw = 1; dst = 1; end
      4'd9:  begin sa = 1; op = 2'b01; ps = 2'b01; pe = z; end
      4'd10: begin pe = 1; ps = 2'b10; end
      4'd11: begin sa = 1; sb_ = 2'b10; end
      4'd12: rw = 1;
      4'd13: begin bz = 1'b0; tp = 1'b1; end
      default: bz = 1'b0;
    endcase
    return {pe, iod, rd, wr, ir, dst, m2r, rw, sa, sb_, op, ps, bz, tp};
  endfunction

  task automatic chk(input logic [3:0] s, input logic done);
    exp_t e, x;
    logic [16:0] obs;
    e.st  = s;
    e.ctl = exp_ctl(s, mem_ready, alu_zero);
    e.cnt = exp_cnt;
    sb.push_back(e);
    #1;
    x = sb.pop_front();
    obs = {pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, busy, trap};
    n_assert++;
    assert (state_o === x.st) else begin
      n_fail++;
      $error("FAIL state obs=%0d exp=%0d", state_o, x.st);
    end
    n_assert++;
    assert (obs === x.ctl) else begin
      n_fail++;
      $error("FAIL ctrl st=%0d obs=%b exp=%b", x.st, obs, x.ctl);
    end
    n_assert++;
    assert (instr_count === x.cnt) else begin
      n_fail++;
      $error("FAIL count st=%0d obs=%0d exp=%0d",
             x.st, instr_count, x.cnt);
    end
    if (done) exp_cnt = exp_cnt + 1;
  endtask

  task automatic cyc(input logic [3:0] s, input logic done);
    chk(s, done);
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(S_IDLE, 0);
    // R-type with run held high
    run = 1; mem_ready = 1; opcode = OP_RTYPE;
    cyc(S_IDLE, 0);
    cyc(S_FETCH, 0);
    cyc(S_DECODE, 0);
    cyc(S_EXEC, 0);
    cyc(S_R_WB, 1);
    // stalled fetch, then async reset in the middle of it
    mem_ready = 0;
    cyc(S_FETCH, 0);
    cyc(S_FETCH, 0);
    #2 rst_n = 1'b0;
    exp_cnt = 0;
    chk(S_IDLE, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run = 1; mem_ready = 1;
    cyc(S_IDLE, 0);
    // lw with two wait cycles
    opcode = OP_LW;
    cyc(S_FETCH, 0);
    cyc(S_DECODE, 0);
    cyc(S_MEM_ADDR, 0);
    mem_ready = 0;
    cyc(S_MEM_RD, 0);
    cyc(S_MEM_RD, 0);
    mem_ready = 1;
    cyc(S_MEM_RD, 0);
    cyc(S_MEM_WB, 1);
    // sw, one wait cycle, fetch with one wait cycle
    opcode = OP_SW;
    mem_ready = 0;
    cyc(S_FETCH, 0);
    mem_ready = 1;
    cyc(S_FETCH, 0);
    cyc(S_DECODE, 0);
    cyc(S_MEM_ADDR, 0);
    mem_ready = 0;
    cyc(S_MEM_WR, 0);
    mem_ready = 1;
    cyc(S_MEM_WR, 1);
    // beq taken then not taken
    opcode = OP_BEQ;
    alu_zero = 1;
    cyc(S_FETCH, 0);
    cyc(S_DECODE, 0);
    cyc(S_BRANCH, 1);
    alu_zero = 0;
    cyc(S_FETCH, 0);
    cyc(S_DECODE, 0);
    cyc(S_BRANCH, 1);
    // j; mem_ready ignored outside memory states
    opcode = OP_J;
    cyc(S_FETCH, 0);
    mem_ready = 0;
    cyc(S_DECODE, 0);
    cyc(S_JUMP, 1);
    mem_ready = 1;
    // addi
    opcode = OP_ADDI;
    cyc(S_FETCH, 0);
    cyc(S_DECODE, 0);
    cyc(S_ADDI_EX, 0);
    cyc(S_ADDI_WB, 1);
    // run dropped during EXEC
    opcode = OP_RTYPE;
    cyc(S_FETCH, 0);
    cyc(S_DECODE, 0);
    run = 0;
    cyc(S_EXEC, 0);
    cyc(S_R_WB, 1);
    cyc(S_IDLE, 0);
    run = 1;
    cyc(S_IDLE, 0);
    // illegal opcode
    opcode = 6'h3f;
    cyc(S_FETCH, 0);
`ifdef MIPS_MC_TRAP_EN
    cyc(S_DECODE, 0);
    cyc(S_TRAP, 0);
    cyc(S_TRAP, 0);
    run = 0;
    cyc(S_TRAP, 0);
`else
    cyc(S_DECODE, 1);
    opcode = OP_J;
    cyc(S_FETCH, 0);
    cyc(S_DECODE, 0);
    run = 0;
    cyc(S_JUMP, 1);
    cyc(S_IDLE, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
